// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE,
    DBG_RESP
  } arb_state_e;

  localparam logic [3:0]  MEM_SEL_ALL = 4'hF;
  localparam int unsigned STARVE_W    = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU, debug and Mem-side signals around the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned MEM_ADDR  = 10,
  parameter int unsigned DATA_BITS = 32
);
  logic                 cpu_req;
  logic                 cpu_we;
  logic [MEM_ADDR-1:0]  cpu_addr;
  logic [DATA_BITS-1:0] cpu_wdata;
  logic [3:0]           cpu_sel;
  logic                 cpu_gnt;
  logic                 cpu_stall;

  logic                 dbg_req;
  logic [MEM_ADDR-1:0]  dbg_addr;
  logic                 dbg_gnt;
  logic                 dbg_valid;
  logic [DATA_BITS-1:0] dbg_rdata;

  logic [MEM_ADDR-1:0]  mem_addr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic [3:0]           mem_sel;
  logic                 mem_str;
  logic [DATA_BITS-1:0] mem_rdata;

  logic [31:0]          stat_conflicts;
  logic [15:0]          stat_forced;

  // Requester / Mem side: drives requests and read data, observes grants.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_sel, dbg_req, dbg_addr, mem_rdata,
    input  cpu_gnt, cpu_stall, dbg_gnt, dbg_valid, dbg_rdata,
    input  mem_addr, mem_wdata, mem_sel, mem_str, stat_conflicts, stat_forced
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_sel, dbg_req, dbg_addr, mem_rdata,
    output cpu_gnt, cpu_stall, dbg_gnt, dbg_valid, dbg_rdata,
    output mem_addr, mem_wdata, mem_sel, mem_str, stat_conflicts, stat_forced
  );
endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of debug losses; raises force_o once the debug port has waited STARVE_MAX.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic force_o
);

  logic [STARVE_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clr_i) begin
      wait_cnt_d = '0;
    end else if (inc_i && (wait_cnt_q != '1)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign force_o = (wait_cnt_q == STARVE_W'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates Mem between the CPU (priority) and a read-only debug port with starvation relief.
// Optional MEM_ARB_STATS_EN adds saturating conflict / forced-slot counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_ADDR   = 10,
  parameter int unsigned DATA_BITS  = 32,
  parameter int unsigned STARVE_MAX = 15
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  arb_state_e           state_q;
  logic                 dbg_valid_q;
  logic [DATA_BITS-1:0] dbg_rdata_q;

  logic both_req, force_dbg, dbg_gnt, cpu_gnt;

  assign both_req = bus.cpu_req & bus.dbg_req;
  assign dbg_gnt  = bus.dbg_req & (state_q == IDLE) & (~bus.cpu_req | force_dbg);
  assign cpu_gnt  = bus.cpu_req & ~dbg_gnt;

  // A cycle where both ask but debug is not served counts as a loss, including DBG_RESP.
  mem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (both_req & ~dbg_gnt),
    .clr_i   (dbg_gnt | ~bus.dbg_req),
    .force_o (force_dbg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dbg_valid_q <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      if (dbg_gnt) begin
        state_q     <= DBG_RESP;
        dbg_valid_q <= 1'b1;
        dbg_rdata_q <= bus.mem_rdata;
      end else begin
        state_q     <= IDLE;
        dbg_valid_q <= 1'b0;
      end
    end
  end

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt;
  assign bus.dbg_gnt   = dbg_gnt;
  assign bus.dbg_valid = dbg_valid_q;
  assign bus.dbg_rdata = dbg_rdata_q;

  assign bus.mem_addr  = cpu_gnt ? bus.cpu_addr : bus.dbg_addr;
  assign bus.mem_wdata = cpu_gnt ? bus.cpu_wdata : '0;
  assign bus.mem_sel   = cpu_gnt ? bus.cpu_sel : MEM_SEL_ALL;
  assign bus.mem_str   = cpu_gnt & bus.cpu_we;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_conflicts_q;
  logic [15:0] stat_forced_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_conflicts_q <= '0;
      stat_forced_q    <= '0;
    end else begin
      if (both_req && (stat_conflicts_q != '1)) begin
        stat_conflicts_q <= stat_conflicts_q + 1'b1;
      end
      // A debug grant while the CPU is asking can only be a forced slot.
      if (dbg_gnt && bus.cpu_req && (stat_forced_q != '1)) begin
        stat_forced_q <= stat_forced_q + 1'b1;
      end
    end
  end

  assign bus.stat_conflicts = stat_conflicts_q;
  assign bus.stat_forced    = stat_forced_q;
`else
  assign bus.stat_conflicts = '0;
  assign bus.stat_forced    = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector table plus starvation, stalled-store and reset sequences for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;

  mem_port_arbiter_if #(.MEM_ADDR(10), .DATA_BITS(32)) bus ();

  mem_port_arbiter #(
    .MEM_ADDR   (10),
    .DATA_BITS  (32),
    .STARVE_MAX (15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  int          wr20_cnt = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_str) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_sel[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
      if (bus.mem_addr == 10'h020) wr20_cnt <= wr20_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [9:0] caddr,
                       input logic [31:0] cwd, input logic [3:0] csel,
                       input logic dreq, input logic [9:0] daddr);
    bus.cpu_req   = creq;
    bus.cpu_we    = cwe;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cwd;
    bus.cpu_sel   = csel;
    bus.dbg_req   = dreq;
    bus.dbg_addr  = daddr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        cpu_req;
    logic        cpu_we;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_sel;
    logic        dbg_req;
    logic [9:0]  dbg_addr;
    logic        e_cgnt;
    logic        e_dgnt;
    logic        e_stall;
    logic        e_str;
    logic [9:0]  e_addr;
    logic        e_valid;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    drive(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0, 10'h0);
    rst_n = 1'b1;

    //           creq we  caddr   cwdata        csel   dreq daddr   cg dg st sr eaddr   ev erdata
    vecs[0]  = '{1'b0,1'b0,10'h000,32'h0,       4'h0,  1'b0,10'h000,0, 0, 0, 0, 10'h000,0, 32'h0};
    vecs[1]  = '{1'b1,1'b1,10'h010,32'hDEADBEEF,4'hF,  1'b0,10'h000,1, 0, 0, 1, 10'h010,0, 32'h0};
    vecs[2]  = '{1'b1,1'b1,10'h011,32'h12345678,4'h3,  1'b0,10'h000,1, 0, 0, 1, 10'h011,0, 32'h0};
    vecs[3]  = '{1'b0,1'b0,10'h000,32'h0,       4'h0,  1'b1,10'h010,0, 1, 0, 0, 10'h010,0, 32'h0};
    vecs[4]  = '{1'b0,1'b0,10'h000,32'h0,       4'h0,  1'b1,10'h010,0, 0, 0, 0, 10'h010,1, 32'hDEADBEEF};
    vecs[5]  = '{1'b0,1'b0,10'h000,32'h0,       4'h0,  1'b1,10'h011,0, 1, 0, 0, 10'h011,0, 32'hDEADBEEF};
    vecs[6]  = '{1'b1,1'b0,10'h030,32'h0,       4'hF,  1'b0,10'h011,1, 0, 0, 0, 10'h030,1, 32'h00005678};
    vecs[7]  = '{1'b1,1'b0,10'h040,32'h0,       4'hF,  1'b1,10'h011,1, 0, 0, 0, 10'h040,0, 32'h00005678};
    vecs[8]  = '{1'b0,1'b0,10'h000,32'h0,       4'h0,  1'b1,10'h010,0, 1, 0, 0, 10'h010,0, 32'h00005678};
    vecs[9]  = '{1'b1,1'b1,10'h012,32'hCAFEF00D,4'hF,  1'b1,10'h010,1, 0, 0, 1, 10'h012,1, 32'hDEADBEEF};
    vecs[10] = '{1'b0,1'b0,10'h000,32'h0,       4'h0,  1'b0,10'h012,0, 0, 0, 0, 10'h012,0, 32'hDEADBEEF};
    vecs[11] = '{1'b0,1'b0,10'h000,32'h0,       4'h0,  1'b1,10'h012,0, 1, 0, 0, 10'h012,0, 32'hDEADBEEF};
    vecs[12] = '{1'b0,1'b0,10'h000,32'h0,       4'h0,  1'b0,10'h012,0, 0, 0, 0, 10'h012,1, 32'hCAFEF00D};

    do_reset();

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].cpu_req, vecs[i].cpu_we, vecs[i].cpu_addr, vecs[i].cpu_wdata,
            vecs[i].cpu_sel, vecs[i].dbg_req, vecs[i].dbg_addr);
      #1;
      check($sformatf("v%0d cpu_gnt", i),   32'(bus.cpu_gnt),   32'(vecs[i].e_cgnt));
      check($sformatf("v%0d dbg_gnt", i),   32'(bus.dbg_gnt),   32'(vecs[i].e_dgnt));
      check($sformatf("v%0d cpu_stall", i), 32'(bus.cpu_stall), 32'(vecs[i].e_stall));
      check($sformatf("v%0d mem_str", i),   32'(bus.mem_str),   32'(vecs[i].e_str));
      check($sformatf("v%0d mem_addr", i),  32'(bus.mem_addr),  32'(vecs[i].e_addr));
      check($sformatf("v%0d dbg_valid", i), 32'(bus.dbg_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d dbg_rdata", i), bus.dbg_rdata,      vecs[i].e_rdata);
    end

    @(negedge clk);
    drive(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0, 10'h0);
    #1;
`ifdef MEM_ARB_STATS_EN
    check("table stat_conflicts", bus.stat_conflicts, 32'd2);
    check("table stat_forced", 32'(bus.stat_forced), 32'd0);
`else
    check("table stat_conflicts", bus.stat_conflicts, 32'd0);
    check("table stat_forced", 32'(bus.stat_forced), 32'd0);
`endif

    // Both held: forced debug slot every 16th cycle; store stalled in the second forced slot.
    do_reset();
    for (int k = 0; k <= 32; k++) begin
      bit forced;
      if (k > 0) @(negedge clk);
      if (k < 31)       drive(1'b1, 1'b0, 10'h050, 32'h0, 4'hF, 1'b1, 10'h010);
      else if (k == 31) drive(1'b1, 1'b1, 10'h020, 32'h1, 4'hF, 1'b1, 10'h010);
      else              drive(1'b1, 1'b1, 10'h020, 32'h1, 4'hF, 1'b0, 10'h010);
      #1;
      forced = (k < 32) && ((k % 16) == 15);
      check($sformatf("starve k%0d cpu_gnt", k),   32'(bus.cpu_gnt),   32'(!forced));
      check($sformatf("starve k%0d dbg_gnt", k),   32'(bus.dbg_gnt),   32'(forced));
      check($sformatf("starve k%0d cpu_stall", k), 32'(bus.cpu_stall), 32'(forced));
      check($sformatf("starve k%0d mem_str", k),   32'(bus.mem_str),   32'(k == 32));
      if (k == 16) begin
        check("starve k16 dbg_valid", 32'(bus.dbg_valid), 32'd1);
        check("starve k16 dbg_rdata", bus.dbg_rdata, 32'hDEADBEEF);
      end
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0, 10'h0);
    #1;
    check("stalled store write count", 32'(wr20_cnt), 32'd1);
    check("stalled store data", mem[10'h020], 32'h1);
`ifdef MEM_ARB_STATS_EN
    check("stat_conflicts", bus.stat_conflicts, 32'd32);
    check("stat_forced", 32'(bus.stat_forced), 32'd2);
`else
    check("stat_conflicts", bus.stat_conflicts, 32'd0);
    check("stat_forced", 32'(bus.stat_forced), 32'd0);
`endif

    // Reset while in DBG_RESP drops the response and restarts the starvation count.
    @(negedge clk);
    drive(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b1, 10'h010);
    #1;
    check("rst seq dbg_gnt", 32'(bus.dbg_gnt), 32'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 10'h050, 32'h0, 4'hF, 1'b1, 10'h010);
    #1;
    check("rst seq pre dbg_valid", 32'(bus.dbg_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst seq dbg_valid", 32'(bus.dbg_valid), 32'd0);
    check("rst seq dbg_rdata", bus.dbg_rdata, 32'h0);
    check("rst seq cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("post rst k%0d dbg_gnt", k), 32'(bus.dbg_gnt), 32'(k == 15));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0, 10'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
